// File: rtl/adder_8bit.sv
// ---------------------------------------------------------------------------
// adder_8bit
//   Registered 8-bit two's-complement adder with carry-in, carry-out and
//   signed-overflow flags. Add/subtract datapath of the Booth multiplier:
//     A+M : b = M,  cin = 0
//     A-M : b = ~M, cin = 1  (cout = 1 means no borrow)
//   Core is two 4-bit carry-lookahead groups. One result per cycle, no stall.
//
//   Build option ADDER_8BIT_INREG_EN: adds an input register stage on
//   a/b/cin/in_valid, raising latency from 1 to 2 cycles.
//
// Ports
//   clk        in   1  clock, all state on posedge
//   rst        in   1  synchronous active-high reset
//   in_valid   in   1  a/b/cin valid this cycle
//   a, b       in   8  operands
//   cin        in   1  carry-in
//   sum        out  8  registered (a+b+cin) mod 256
//   cout       out  1  registered carry out of bit 7
//   ovf        out  1  registered signed overflow (c7 ^ c8)
//   out_valid  out  1  outputs carry a new result this cycle
// ---------------------------------------------------------------------------
module adder_8bit (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic       cin,
   output logic [7:0] sum,
   output logic       cout,
   output logic       ovf,
   output logic       out_valid
);

   // Flattened lookahead carries c1..c4 of one 4-bit group.
   function automatic logic [4:1] cla4(input logic [3:0] g,
                                       input logic [3:0] p,
                                       input logic       ci);
      logic [4:1] c;
      c[1] = g[0] | (p[0] & ci);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
           | (p[2] & p[1] & p[0] & ci);
      c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
           | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & ci);
      return c;
   endfunction

   // Operand stage feeding the adder core.
   logic [7:0] op_a;
   logic [7:0] op_b;
   logic       op_cin;
   logic       op_vld;

`ifdef ADDER_8BIT_INREG_EN
   logic [7:0] a_q, a_d;
   logic [7:0] b_q, b_d;
   logic       cin_q, cin_d;
   logic       vld_q;

   // Operands are captured only with in_valid so X/Z on idle inputs never
   // enters the pipeline.
   always_comb begin
      a_d   = a_q;
      b_d   = b_q;
      cin_d = cin_q;
      if (in_valid) begin
         a_d   = a;
         b_d   = b;
         cin_d = cin;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_q   <= 8'h00;
         b_q   <= 8'h00;
         cin_q <= 1'b0;
         vld_q <= 1'b0;
      end else begin
         a_q   <= a_d;
         b_q   <= b_d;
         cin_q <= cin_d;
         vld_q <= in_valid;
      end
   end

   assign op_a   = a_q;
   assign op_b   = b_q;
   assign op_cin = cin_q;
   assign op_vld = vld_q;
`else
   assign op_a   = a;
   assign op_b   = b;
   assign op_cin = cin;
   assign op_vld = in_valid;
`endif

   logic [7:0] g;
   logic [7:0] p;
   logic [4:1] c_lo;
   logic [4:1] c_hi;
   logic [8:0] carry;

   assign g     = op_a & op_b;
   assign p     = op_a ^ op_b;
   assign c_lo  = cla4(g[3:0], p[3:0], op_cin);
   assign c_hi  = cla4(g[7:4], p[7:4], c_lo[4]);
   assign carry = {c_hi, c_lo, op_cin};

   logic [7:0] sum_q, sum_d;
   logic       cout_q, cout_d;
   logic       ovf_q, ovf_d;
   logic       vld_o_q;

   // Result registers load only on a valid operation; otherwise they hold.
   always_comb begin
      sum_d  = sum_q;
      cout_d = cout_q;
      ovf_d  = ovf_q;
      if (op_vld) begin
         sum_d  = p ^ carry[7:0];
         cout_d = carry[8];
         ovf_d  = carry[7] ^ carry[8];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sum_q   <= 8'h00;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         vld_o_q <= 1'b0;
      end else begin
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
         vld_o_q <= op_vld;
      end
   end

   assign sum       = sum_q;
   assign cout      = cout_q;
   assign ovf       = ovf_q;
   assign out_valid = vld_o_q;

endmodule

// File: tb/tb_adder_8bit.sv
module tb_adder_8bit;

`ifdef ADDER_8BIT_INREG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic [7:0] a;
   logic [7:0] b;
   logic       cin;
   logic [7:0] sum;
   logic       cout;
   logic       ovf;
   logic       out_valid;

   adder_8bit dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf),
      .out_valid (out_valid)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] sum;
      logic       cout;
      logic       ovf;
      int         due;
   } exp_t;

   exp_t q[$];
   exp_t hold;
   int   cyc    = 0;
   int   ntests = 0;
   int   nfail  = 0;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
      ntests++;
      assert (obs === expv) else begin
         nfail++;
         $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, expv);
      end
   endtask

   // Drive one cycle, update the scoreboard, then check outputs 1 time unit
   // after the edge.
   task automatic step(input logic r, input logic v, input logic [7:0] ta,
                       input logic [7:0] tb, input logic tc);
      exp_t       e;
      logic [8:0] s9;
      logic       exp_vld;
      rst      = r;
      in_valid = v;
      a        = ta;
      b        = tb;
      cin      = tc;
      @(posedge clk);
      cyc++;
      if (r) begin
         q.delete();
         hold.sum  = 8'h00;
         hold.cout = 1'b0;
         hold.ovf  = 1'b0;
      end else if (v) begin
         s9     = {1'b0, ta} + {1'b0, tb} + {8'h00, tc};
         e.sum  = s9[7:0];
         e.cout = s9[8];
         e.ovf  = (ta[7] == tb[7]) && (s9[7] != ta[7]);
         e.due  = cyc + LAT - 1;
         q.push_back(e);
      end
      #1;
      exp_vld = (q.size() > 0) && (q[0].due == cyc);
      if (exp_vld) hold = q.pop_front();
      chk("out_valid", {7'd0, out_valid}, {7'd0, exp_vld});
      chk("sum",       sum,               hold.sum);
      chk("cout",      {7'd0, cout},      {7'd0, hold.cout});
      chk("ovf",       {7'd0, ovf},       {7'd0, hold.ovf});
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'hxx, 8'hxx, 1'bx);
   endtask

   initial begin
      hold.sum = 8'h00; hold.cout = 1'b0; hold.ovf = 1'b0; hold.due = 0;

      // 1: reset overrides in_valid
      step(1'b1, 1'b1, 8'h55, 8'h00, 1'b0);
      step(1'b1, 1'b1, 8'h55, 8'h00, 1'b0);
      idle(3);

      // 2: simple add then hold with X inputs
      step(1'b0, 1'b1, 8'h05, 8'h03, 1'b0);
      idle(LAT + 2);

      // 3: wrap and overflow back to back
      step(1'b0, 1'b1, 8'hFF, 8'h01, 1'b0);
      step(1'b0, 1'b1, 8'h7F, 8'h01, 1'b0);
      idle(LAT);

      // 4: subtraction
      step(1'b0, 1'b1, 8'h03, 8'hFA, 1'b1);
      step(1'b0, 1'b1, 8'h05, 8'hFC, 1'b1);
      step(1'b0, 1'b1, 8'hFF, 8'hFF, 1'b1);
      idle(LAT);

      // 5: 80+80, then reset mid-stream with operations in flight
      step(1'b0, 1'b1, 8'h80, 8'h80, 1'b0);
      idle(LAT);
      step(1'b0, 1'b1, 8'h12, 8'h34, 1'b0);
      step(1'b1, 1'b1, 8'h56, 8'h78, 1'b1);
      idle(LAT + 2);

      // 6: random stream
      for (int i = 0; i < 10000; i++) begin
         if ($urandom_range(0, 3) != 0)
            step(1'b0, 1'b1, 8'($urandom), 8'($urandom), 1'($urandom));
         else
            step(1'b0, 1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
      end
      idle(LAT + 1);

      ntests++;
      assert (q.size() == 0) else begin
         nfail++;
         $error("FAIL drain observed=%0d pending expected=0", q.size());
      end

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
